// File: rtl/johnson_seq_ctrl_if.sv
// Command/status bundle between a controller (master) and johnson_seq_ctrl (slave).
// Commands and tick/dir/load_val/rot_target flow master->slave.
// q/phase/rot_cnt/busy/done/err flow slave->master.
interface johnson_seq_ctrl_if #(
  parameter int N  = 4,
  parameter int RW = 8,
  parameter int PW = 4
);
  logic          tick;
  logic          dir;
  logic          start;
  logic          stop;
  logic          step;
  logic          clear;
  logic          load;
  logic [N-1:0]  load_val;
  logic [RW-1:0] rot_target;
  logic [N-1:0]  q;
  logic [PW-1:0] phase;
  logic [RW-1:0] rot_cnt;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    output tick, dir, start, stop, step, clear, load, load_val, rot_target,
    input  q, phase, rot_cnt, busy, done, err
  );

  modport slave (
    input  tick, dir, start, stop, step, clear, load, load_val, rot_target,
    output q, phase, rot_cnt, busy, done, err
  );
endinterface

// File: rtl/johnson_seq_ctrl.sv
// Purpose: N-bit Johnson counter sequencer with start/stop/step/clear/load and rotation counting.
// Latency: command/tick in cycle t updates q/state/flags at the edge ending cycle t; phase is combinational from q.
// Backpressure: none; one command acts per cycle by priority, and any asserted command masks tick.
// Ports: clk, rst (async active-low), bus (johnson_seq_ctrl_if.slave): commands, tick, dir, load_val,
//        rot_target in; q, phase, rot_cnt, busy, done, err out.
module johnson_seq_ctrl #(
  parameter int N  = 4,
  parameter int RW = 8,
  parameter int PW = 4
) (
  input  logic               clk,
  input  logic               rst,
  johnson_seq_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  q_q, q_d;
  logic [RW-1:0] rot_cnt_q, rot_cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [N-1:0]  step_val;
  logic [RW-1:0] rot_inc;
  logic          idle_like;

  function automatic logic [N-1:0] fwd(input logic [N-1:0] v);
    return {v[N-2:0], ~v[N-1]};
  endfunction

  function automatic logic [N-1:0] rev(input logic [N-1:0] v);
    return {~v[0], v[N-1:1]};
  endfunction

  // Mask with the k least significant bits set.
  function automatic logic [N-1:0] lsb_ones(input int k);
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) m[i] = (i < k);
    return m;
  endfunction

  // Legal codes are a run of ones anchored at the LSB (including all-zeros
  // and all-ones) or a run of ones anchored at the MSB.
  function automatic logic is_legal(input logic [N-1:0] v);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k <= N; k++) if (v == lsb_ones(k)) ok = 1'b1;
    for (int k = 1; k < N; k++) if (v == ~lsb_ones(N - k)) ok = 1'b1;
    return ok;
  endfunction

  // Ones anchored at the LSB mean we are k steps into the filling half;
  // otherwise the zeros are filling from the bottom and we are 2N-k in.
  function automatic logic [PW-1:0] phase_of(input logic [N-1:0] v);
    int ones;
    ones = 0;
    for (int i = 0; i < N; i++) if (v[i]) ones++;
    if (v[0] || ones == 0) return PW'(ones);
    return PW'(2 * N - ones);
  endfunction

  assign step_val  = bus.dir ? rev(q_q) : fwd(q_q);
  assign rot_inc   = rot_cnt_q + RW'(1);
  assign idle_like = (state_q != RUN);

  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    rot_cnt_d = rot_cnt_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    // Highest asserted command owns the cycle even when its own state
    // condition makes it a no-op; tick only acts in a command-free cycle.
    if (bus.clear) begin
      state_d   = IDLE;
      q_d       = '0;
      rot_cnt_d = '0;
    end else if (bus.stop) begin
      if (state_q == RUN) state_d = IDLE;
    end else if (bus.start) begin
      if (idle_like) begin
        state_d   = RUN;
        rot_cnt_d = '0;
      end
    end else if (bus.load) begin
      if (idle_like) begin
        if (is_legal(bus.load_val)) begin
          q_d = bus.load_val;
        end else begin
          q_d   = '0;
          err_d = 1'b1;
        end
      end
    end else if (bus.step) begin
      if (idle_like) q_d = step_val;
    end else if (bus.tick && state_q == RUN) begin
      q_d = step_val;
      // Only landings on all-zeros count, whichever direction got us there.
      if (step_val == '0) begin
        rot_cnt_d = rot_inc;
        if (bus.rot_target != '0 && rot_inc == bus.rot_target) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
    end

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      q_q       <= '0;
      rot_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      rot_cnt_q <= rot_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.q       = q_q;
  assign bus.phase   = phase_of(q_q);
  assign bus.rot_cnt = rot_cnt_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Directed, table-driven bench for johnson_seq_ctrl (N=4, RW=8, PW=4).
// Each vector drives one cycle of inputs and checks q/phase/rot_cnt/busy/done/err after the edge.
module tb_johnson_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  johnson_seq_ctrl_if #(.N(4), .RW(8), .PW(4)) bus ();

  johnson_seq_ctrl #(.N(4), .RW(8), .PW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // cmd bits: [5]clear [4]stop [3]start [2]load [1]step [0]tick
  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] TICK = 6'b000001;
  localparam logic [5:0] STEP = 6'b000010;
  localparam logic [5:0] LOAD = 6'b000100;
  localparam logic [5:0] STRT = 6'b001000;
  localparam logic [5:0] STOP = 6'b010000;
  localparam logic [5:0] CLR  = 6'b100000;

  // flags: {busy, done, err}
  typedef struct {
    string      name;
    logic [5:0] cmd;
    logic       dir;
    logic [3:0] lv;
    logic [7:0] tgt;
    logic [3:0] eq;
    logic [3:0] eph;
    logic [7:0] erot;
    logic [2:0] eflags;
  } vec_t;

  int errors = 0;
  int checks = 0;
  vec_t vecs[$];

  function automatic vec_t mk(string n, logic [5:0] c, logic d, logic [3:0] lv, logic [7:0] t,
                              logic [3:0] eq, logic [3:0] eph, logic [7:0] er, logic [2:0] f);
    vec_t v;
    v.name = n; v.cmd = c; v.dir = d; v.lv = lv; v.tgt = t;
    v.eq = eq; v.eph = eph; v.erot = er; v.eflags = f;
    return v;
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    bus.clear      = v.cmd[5];
    bus.stop       = v.cmd[4];
    bus.start      = v.cmd[3];
    bus.load       = v.cmd[2];
    bus.step       = v.cmd[1];
    bus.tick       = v.cmd[0];
    bus.dir        = v.dir;
    bus.load_val   = v.lv;
    bus.rot_target = v.tgt;
  endtask

  task automatic check_outs(vec_t v);
    chk({v.name, "/q"},       8'(bus.q),     8'(v.eq));
    chk({v.name, "/phase"},   8'(bus.phase), 8'(v.eph));
    chk({v.name, "/rot_cnt"}, bus.rot_cnt,   v.erot);
    chk({v.name, "/busy"},    8'(bus.busy),  8'(v.eflags[2]));
    chk({v.name, "/done"},    8'(bus.done),  8'(v.eflags[1]));
    chk({v.name, "/err"},     8'(bus.err),   8'(v.eflags[0]));
  endtask

  task automatic cycle(vec_t v);
    drive(v);
    @(posedge clk);
    #1;
    check_outs(v);
  endtask

  initial begin
    logic [3:0] fseq[8];
    logic [3:0] fph[8];
    logic [7:0] er;
    logic [2:0] fl;

    fseq[0] = 4'b0001; fseq[1] = 4'b0011; fseq[2] = 4'b0111; fseq[3] = 4'b1111;
    fseq[4] = 4'b1110; fseq[5] = 4'b1100; fseq[6] = 4'b1000; fseq[7] = 4'b0000;
    fph[0] = 4'd1; fph[1] = 4'd2; fph[2] = 4'd3; fph[3] = 4'd4;
    fph[4] = 4'd5; fph[5] = 4'd6; fph[6] = 4'd7; fph[7] = 4'd0;

    // Reset held while ticks and commands are active.
    rst = 1'b0;
    drive(mk("rst", STRT | TICK | STEP, 1'b0, 4'b0111, 8'd0, 4'd0, 4'd0, 8'd0, 3'b000));
    repeat (3) @(posedge clk);
    #1;
    check_outs(mk("t1_reset", NONE, 1'b0, 4'd0, 8'd0, 4'b0000, 4'd0, 8'd0, 3'b000));
    drive(mk("idle", NONE, 1'b0, 4'd0, 8'd0, 4'd0, 4'd0, 8'd0, 3'b000));
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors, hand-computed for N=4.
    vecs.push_back(mk("t3_rev1",      STEP,        1'b1, 4'd0,    8'd0, 4'b1000, 4'd7, 8'd0, 3'b000));
    vecs.push_back(mk("t3_rev2",      STEP,        1'b1, 4'd0,    8'd0, 4'b1100, 4'd6, 8'd0, 3'b000));
    vecs.push_back(mk("t3_rev3",      STEP,        1'b1, 4'd0,    8'd0, 4'b1110, 4'd5, 8'd0, 3'b000));
    vecs.push_back(mk("step_fwd",     STEP,        1'b0, 4'd0,    8'd0, 4'b1100, 4'd6, 8'd0, 3'b000));
    vecs.push_back(mk("idle_tick",    TICK,        1'b0, 4'd0,    8'd0, 4'b1100, 4'd6, 8'd0, 3'b000));
    vecs.push_back(mk("clear_idle",   CLR,         1'b0, 4'd0,    8'd0, 4'b0000, 4'd0, 8'd0, 3'b000));
    vecs.push_back(mk("t5_load_ok",   LOAD,        1'b0, 4'b0111, 8'd0, 4'b0111, 4'd3, 8'd0, 3'b000));
    vecs.push_back(mk("t5_load_msb",  LOAD,        1'b0, 4'b1100, 8'd0, 4'b1100, 4'd6, 8'd0, 3'b000));
    vecs.push_back(mk("t5_load_bad",  LOAD,        1'b0, 4'b0101, 8'd0, 4'b0000, 4'd0, 8'd0, 3'b001));
    vecs.push_back(mk("t5_err_gone",  NONE,        1'b0, 4'd0,    8'd0, 4'b0000, 4'd0, 8'd0, 3'b000));
    vecs.push_back(mk("t4_start",     STRT | TICK, 1'b0, 4'd0,    8'd0, 4'b0000, 4'd0, 8'd0, 3'b100));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk($sformatf("t4_tick%0d", i + 1), TICK, 1'b0, 4'd0, 8'd0, fseq[i], fph[i], 8'd0, 3'b100));
    vecs.push_back(mk("t4_stop",      STOP | TICK, 1'b0, 4'd0,    8'd0, 4'b1110, 4'd5, 8'd0, 3'b000));
    vecs.push_back(mk("t4_resume",    STRT | TICK, 1'b0, 4'd0,    8'd0, 4'b1110, 4'd5, 8'd0, 3'b100));
    vecs.push_back(mk("t5_load_busy", LOAD,        1'b0, 4'b0011, 8'd0, 4'b1110, 4'd5, 8'd0, 3'b100));
    vecs.push_back(mk("step_busy",    STEP,        1'b0, 4'd0,    8'd0, 4'b1110, 4'd5, 8'd0, 3'b100));
    vecs.push_back(mk("t4_tick6",     TICK,        1'b0, 4'd0,    8'd0, 4'b1100, 4'd6, 8'd0, 3'b100));
    vecs.push_back(mk("t4_tick7",     TICK,        1'b0, 4'd0,    8'd0, 4'b1000, 4'd7, 8'd0, 3'b100));
    vecs.push_back(mk("t4_land",      TICK,        1'b0, 4'd0,    8'd0, 4'b0000, 4'd0, 8'd1, 3'b100));
    vecs.push_back(mk("t6_prio",      CLR | STRT | TICK, 1'b0, 4'd0, 8'd0, 4'b0000, 4'd0, 8'd0, 3'b000));
    vecs.push_back(mk("t6_start",     STRT,        1'b0, 4'd0,    8'd0, 4'b0000, 4'd0, 8'd0, 3'b100));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk($sformatf("t6_tick%0d", i + 1), TICK, 1'b0, 4'd0, 8'd0, fseq[i], fph[i],
                        (i == 7) ? 8'd1 : 8'd0, 3'b100));
    vecs.push_back(mk("dir_rev",      TICK,        1'b1, 4'd0,    8'd0, 4'b1000, 4'd7, 8'd1, 3'b100));
    vecs.push_back(mk("dir_fwd_land", TICK,        1'b0, 4'd0,    8'd0, 4'b0000, 4'd0, 8'd2, 3'b100));
    vecs.push_back(mk("dir_fwd",      TICK,        1'b0, 4'd0,    8'd0, 4'b0001, 4'd1, 8'd2, 3'b100));
    vecs.push_back(mk("rev_land",     TICK,        1'b1, 4'd0,    8'd0, 4'b0000, 4'd0, 8'd3, 3'b100));
    vecs.push_back(mk("stop_hold",    STOP,        1'b0, 4'd0,    8'd0, 4'b0000, 4'd0, 8'd3, 3'b000));
    vecs.push_back(mk("stop_idle",    STOP | TICK, 1'b0, 4'd0,    8'd0, 4'b0000, 4'd0, 8'd3, 3'b000));
    vecs.push_back(mk("start_zero",   STRT,        1'b0, 4'd0,    8'd0, 4'b0000, 4'd0, 8'd0, 3'b100));
    vecs.push_back(mk("clear_run",    CLR,         1'b0, 4'd0,    8'd0, 4'b0000, 4'd0, 8'd0, 3'b000));

    foreach (vecs[i]) cycle(vecs[i]);

    // Two full forward rotations to a target of 2.
    cycle(mk("t2_start", STRT | TICK, 1'b0, 4'd0, 8'd2, 4'b0000, 4'd0, 8'd0, 3'b100));
    for (int i = 1; i <= 16; i++) begin
      er = (i == 16) ? 8'd2 : (i >= 8) ? 8'd1 : 8'd0;
      fl = (i == 16) ? 3'b010 : 3'b100;
      cycle(mk($sformatf("t2_tick%0d", i), TICK, 1'b0, 4'd0, 8'd2, fseq[(i - 1) % 8], fph[(i - 1) % 8], er, fl));
    end
    cycle(mk("t2_hold",      NONE, 1'b0, 4'd0,    8'd2, 4'b0000, 4'd0, 8'd2, 3'b000));
    cycle(mk("t2_tick_done", TICK, 1'b0, 4'd0,    8'd2, 4'b0000, 4'd0, 8'd2, 3'b000));
    cycle(mk("t2_step_done", STEP, 1'b0, 4'd0,    8'd2, 4'b0001, 4'd1, 8'd2, 3'b000));
    cycle(mk("t2_load_done", LOAD, 1'b0, 4'b0011, 8'd2, 4'b0011, 4'd2, 8'd2, 3'b000));
    cycle(mk("t2_restart",   STRT, 1'b0, 4'd0,    8'd2, 4'b0011, 4'd2, 8'd0, 3'b100));
    cycle(mk("t2_run_on",    TICK, 1'b0, 4'd0,    8'd2, 4'b0111, 4'd3, 8'd0, 3'b100));

    // Asynchronous reset asserted between edges mid-run, released, then a tick in IDLE.
    #2 rst = 1'b0;
    #1 check_outs(mk("arst_mid", NONE, 1'b0, 4'd0, 8'd2, 4'b0000, 4'd0, 8'd0, 3'b000));
    #1 rst = 1'b1;
    cycle(mk("arst_idle", TICK, 1'b0, 4'd0, 8'd2, 4'b0000, 4'd0, 8'd0, 3'b000));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
